// File: rtl/sobel_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_filter_if
// Description : Show-ahead input FIFO pop port and output FIFO push port.
// Revision    : 1.0
// ============================================================================
interface sobel_filter_if #(
    parameter int GRAY_DATA_WIDTH = 8
) ();
    logic                       in_rd_en;
    logic                       in_empty;
    logic [GRAY_DATA_WIDTH-1:0] in_dout;
    logic                       out_wr_en;
    logic                       out_full;
    logic [GRAY_DATA_WIDTH-1:0] out_din;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );
endinterface
`default_nettype wire

// File: rtl/sobel_filter.sv
`default_nettype none
// ============================================================================
// Module      : sobel_filter
// Description : Streaming 3x3 Sobel gradient magnitude over a padded frame.
// Revision    : 1.0
// ============================================================================
module sobel_filter #(
    parameter int GRAY_DATA_WIDTH = 8,
    parameter int PAD_WIDTH       = 722,
    parameter int PAD_HEIGHT      = 722
) (
    input  wire logic      clock,
    input  wire logic      reset,
    sobel_filter_if.master fifo
);
    localparam int c_DEPTH = 2 * PAD_WIDTH + 3;
    localparam int c_COL_W = $clog2(PAD_WIDTH);
    localparam int c_ROW_W = $clog2(PAD_HEIGHT);
    localparam int c_ACC_W = GRAY_DATA_WIDTH + 3;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(PAD_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(PAD_HEIGHT - 1);
    localparam logic [c_ACC_W-1:0] c_PIX_MAX  = {3'b000, {GRAY_DATA_WIDTH{1'b1}}};

    typedef enum logic [0:0] {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_win_valid;
    logic [c_COL_W-1:0]         r_col;
    logic [c_ROW_W-1:0]         r_row;
    logic [GRAY_DATA_WIDTH-1:0] r_result;
    logic [GRAY_DATA_WIDTH-1:0] r_line [c_DEPTH];
    logic [GRAY_DATA_WIDTH-1:0] w_p [3][3];

    logic signed [c_ACC_W-1:0]  w_gx;
    logic signed [c_ACC_W-1:0]  w_gy;
    logic        [c_ACC_W-1:0]  w_abs_gx;
    logic        [c_ACC_W-1:0]  w_abs_gy;
    logic        [c_ACC_W-1:0]  w_mag;
    logic [GRAY_DATA_WIDTH-1:0] w_result;

    function automatic logic signed [c_ACC_W-1:0] ext(input logic [GRAY_DATA_WIDTH-1:0] v);
        return $signed({3'b000, v});
    endfunction

    // Line buffer carries no reset: window validity comes from the counters.
    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_line[0] <= fifo.in_dout;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    // Window is taken as it will look after this cycle's shift.
    for (genvar r = 0; r < 3; r++) begin : g_win_row
        for (genvar c = 0; c < 3; c++) begin : g_win_col
            localparam int c_IDX = (2 - r) * PAD_WIDTH + (2 - c);
            if (c_IDX == 0) begin : g_newest
                assign w_p[r][c] = fifo.in_dout;
            end else begin : g_buffered
                assign w_p[r][c] = r_line[c_IDX-1];
            end
        end
    end

    always_comb begin
        w_gx = (ext(w_p[0][0]) + (ext(w_p[1][0]) <<< 1) + ext(w_p[2][0]))
             - (ext(w_p[0][2]) + (ext(w_p[1][2]) <<< 1) + ext(w_p[2][2]));
        w_gy = (ext(w_p[0][0]) + (ext(w_p[0][1]) <<< 1) + ext(w_p[0][2]))
             - (ext(w_p[2][0]) + (ext(w_p[2][1]) <<< 1) + ext(w_p[2][2]));
        w_abs_gx = w_gx[c_ACC_W-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_abs_gy = w_gy[c_ACC_W-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
        w_mag    = (w_abs_gx + w_abs_gy) >> 1;
        w_result = (w_mag > c_PIX_MAX) ? {GRAY_DATA_WIDTH{1'b1}} : w_mag[GRAY_DATA_WIDTH-1:0];
    end

    assign w_win_valid = (r_row >= c_ROW_W'(2)) && (r_col >= c_COL_W'(2));

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_READ: begin
                if (!fifo.in_empty) begin
                    w_pop = 1'b1;
                    if (w_win_valid) begin
                        w_state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!fifo.out_full) begin
                    w_push       = 1'b1;
                    w_state_next = S_READ;
                end
            end
            default: w_state_next = S_READ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_READ;
            r_col    <= '0;
            r_row    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                if (w_win_valid) begin
                    r_result <= w_result;
                end
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign fifo.in_rd_en  = w_pop;
    assign fifo.out_wr_en = w_push;
    assign fifo.out_din   = r_result;
endmodule
`default_nettype wire

// File: tb/tb_sobel_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_filter
// Description : Scoreboard bench for sobel_filter on 6x6 directed frames.
// Revision    : 1.0
// ============================================================================
module tb_sobel_filter;
    localparam int PW = 6;
    localparam int PH = 6;

    localparam int K_UNI  = 0;  // all 100
    localparam int K_V40  = 1;  // cols 3-5 = 40
    localparam int K_V255 = 2;  // cols 3-5 = 255
    localparam int K_H40  = 3;  // rows 3-5 = 40
    localparam int K_IMP  = 4;  // single 100 at (2,2)

    logic clock = 1'b0;
    logic reset = 1'b1;

    sobel_filter_if #(.GRAY_DATA_WIDTH(8)) bus ();

    sobel_filter #(
        .GRAY_DATA_WIDTH(8),
        .PAD_WIDTH      (PW),
        .PAD_HEIGHT     (PH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fifo (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] pix_q [$];
    logic [7:0] exp_q [$];
    int n_cmp     = 0;
    int n_err     = 0;
    int pops      = 0;
    int bp_left   = 0;
    bit bp_arm    = 1'b0;
    bit starve_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        case (kind)
            K_UNI:   return 8'd100;
            K_V40:   return (c >= 3) ? 8'd40 : 8'd0;
            K_V255:  return (c >= 3) ? 8'd255 : 8'd0;
            K_H40:   return (r >= 3) ? 8'd40 : 8'd0;
            default: return (r == 2 && c == 2) ? 8'd100 : 8'd0;
        endcase
    endfunction

    // Hand-derived results per output position (orow, ocol in 0..3).
    function automatic logic [7:0] expv(input int kind, input int orow, input int ocol);
        case (kind)
            K_UNI:   return 8'd0;
            K_V40:   return (ocol == 1 || ocol == 2) ? 8'd80 : 8'd0;
            K_V255:  return (ocol == 1 || ocol == 2) ? 8'd255 : 8'd0;
            K_H40:   return (orow == 1 || orow == 2) ? 8'd80 : 8'd0;
            default: return (orow <= 2 && ocol <= 2 && !(orow == 1 && ocol == 1)) ? 8'd100 : 8'd0;
        endcase
    endfunction

    task automatic load_frame(input int kind, input int npix);
        for (int i = 0; i < npix; i++) begin
            int r = i / PW;
            int c = i % PW;
            pix_q.push_back(pix(kind, r, c));
            if (r >= 2 && c >= 2) exp_q.push_back(expv(kind, r - 2, c - 2));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((pix_q.size() != 0 || exp_q.size() != 0) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check("drain_pending", pix_q.size() + exp_q.size(), 0);
        pix_q.delete();
        exp_q.delete();
        repeat (6) @(negedge clock);
        #2;
    endtask

    // Input FIFO / output-full driver.
    initial begin
        bus.in_empty = 1'b1;
        bus.in_dout  = 8'h00;
        bus.out_full = 1'b0;
        forever begin
            @(negedge clock);
            if (bp_arm && pops == 15) begin
                bp_arm  = 1'b0;
                bp_left = 10;
            end
            bus.out_full = (bp_left > 0);
            bus.in_empty = reset || (pix_q.size() == 0) || (starve_en && $urandom_range(0, 2) == 0);
            bus.in_dout  = (pix_q.size() != 0) ? pix_q[0] : 8'h00;
            #1;
            if (bp_left > 0) begin
                bp_left--;
                check("bp_no_pop", int'(bus.in_rd_en), 0);
                check("bp_no_push", int'(bus.out_wr_en), 0);
                check("bp_result_held", int'(bus.out_din), 100);
            end
            if (bus.in_empty && (starve_en || bus.in_rd_en))
                check("no_pop_when_empty", int'(bus.in_rd_en), 0);
            if (bus.in_rd_en && !bus.in_empty) begin
                void'(pix_q.pop_front());
                pops++;
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            #1;
            if (bus.out_wr_en) begin
                check("push_excl_pop", int'(bus.in_rd_en), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_push", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_din", int'(bus.out_din), int'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        check("rst_in_rd_en", int'(bus.in_rd_en), 0);
        check("rst_out_wr_en", int'(bus.out_wr_en), 0);
        check("rst_out_din", int'(bus.out_din), 0);

        load_frame(K_UNI, 36);
        wait_drain();

        // back-to-back frames exercise the row wrap
        load_frame(K_V40, 36);
        load_frame(K_V255, 36);
        wait_drain();
        load_frame(K_H40, 36);
        load_frame(K_IMP, 36);
        wait_drain();

        starve_en = 1'b1;
        load_frame(K_UNI, 36);
        load_frame(K_V40, 36);
        wait_drain();
        starve_en = 1'b0;

        // first result of the impulse frame (100) is held under out_full
        pops   = 0;
        bp_arm = 1'b1;
        load_frame(K_IMP, 36);
        wait_drain();

        // partial frame, then reset mid-frame
        load_frame(K_V255, 17);
        wait_drain();
        reset = 1'b1;
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        check("midrst_out_wr_en", int'(bus.out_wr_en), 0);
        check("midrst_out_din", int'(bus.out_din), 0);
        load_frame(K_IMP, 36);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
